st_link_tx_sched: RTL and testbench

//  - Round-robin scheduler and serializer for the self-test serial link transmit side.
//  - Arbitrates NUM_REQ requesters, each offering one 32-bit word per frame.
//  - Drives the single-bit link: idle low, then preamble 4'b1010, then 32 payload bits MSB-first, then an idle gap.
//  - Sits opposite the receive-side deserializer. The gap guarantees the receiver's preamble search is flushed between frames.

---
 rtl/st_link_tx_sched_if.sv | 41 ++++
 rtl/st_link_tx_sched.sv | 175 +++++++++++++++++
 tb/tb_st_link_tx_sched.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/st_link_tx_sched_if.sv
// rtl/st_link_tx_sched_if.sv - requester handshake and serial link bundle for st_link_tx_sched
`timescale 1ns/1ps

interface st_link_tx_sched_if #(
    parameter int NUM_REQ = 4
) ();
    localparam int GID_W = $clog2(NUM_REQ);

    logic                   enable;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ*32-1:0]  req_data;
    logic [NUM_REQ-1:0]     req_ready;
    logic                   sdo;
    logic                   busy;
    logic [GID_W-1:0]       grant_id;
    logic                   frame_done;

    // requester/link-consumer side
    modport master (
        output enable,
        output req_valid,
        output req_data,
        input  req_ready,
        input  sdo,
        input  busy,
        input  grant_id,
        input  frame_done
    );

    // scheduler side
    modport slave (
        input  enable,
        input  req_valid,
        input  req_data,
        output req_ready,
        output sdo,
        output busy,
        output grant_id,
        output frame_done
    );
endinterface

// File: rtl/st_link_tx_sched.sv
// rtl/st_link_tx_sched.sv - round-robin scheduler and serializer for the self-test link TX (optional stats: ST_LINK_TX_STATS_EN)
`timescale 1ns/1ps

module st_link_tx_sched #(
    parameter int NUM_REQ    = 4,
    parameter int PAYLOAD_W  = 32,
    parameter int GAP_CYCLES = 8
) (
    input  logic                t_clk,
    input  logic                rst_n,
    st_link_tx_sched_if.slave   bus
`ifdef ST_LINK_TX_STATS_EN
    ,
    output logic [15:0]         frame_cnt,
    output logic [NUM_REQ-1:0]  grant_hist
`endif
);

    localparam int GID_W = $clog2(NUM_REQ);

    // Elaboration-time parameter legality; the 6-bit shared counter bounds the gap length.
    generate
        if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
            $error("st_link_tx_sched: NUM_REQ must be in 2..8");
        end
        if (PAYLOAD_W != 32) begin : g_bad_payload_w
            $error("st_link_tx_sched: PAYLOAD_W must be 32");
        end
        if (GAP_CYCLES < 4 || GAP_CYCLES > 64) begin : g_bad_gap
            $error("st_link_tx_sched: GAP_CYCLES must be in 4..64");
        end
    endgenerate

    // Last counter value of each phase; the counter restarts at 0 on every phase entry.
    localparam logic [5:0] PRE_LAST  = 6'd3;
    localparam logic [5:0] DATA_LAST = 6'(PAYLOAD_W - 1);
    localparam logic [5:0] GAP_DONE  = 6'(GAP_CYCLES - 2);
    localparam logic [5:0] GAP_LAST  = 6'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRE  = 2'd1,
        S_DATA = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    state_t             r_state;
    logic [5:0]         r_cnt;
    logic [31:0]        r_shift;
    logic [GID_W-1:0]   r_ptr;
    logic [GID_W-1:0]   r_grant_id;
    logic               r_sdo;
    logic               r_busy;
    logic               r_frame_done;

    logic               w_any;
    logic [GID_W-1:0]   w_win;
    logic               w_accept;
    logic [NUM_REQ-1:0] w_ready;
    logic [31:0]        w_win_data;

    // Round-robin search: first valid requester upward from the last winner, with wrap.
    always_comb begin
        w_any = 1'b0;
        w_win = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!w_any && bus.req_valid[(int'(r_ptr) + k) % NUM_REQ]) begin
                w_any = 1'b1;
                w_win = GID_W'((int'(r_ptr) + k) % NUM_REQ);
            end
        end
    end

    // Grants only in IDLE with enable high; gating with rst_n keeps ready low while held in reset.
    assign w_accept   = (r_state == S_IDLE) && bus.enable && w_any && rst_n;
    assign w_ready    = w_accept ? (NUM_REQ'(1) << w_win) : '0;
    assign w_win_data = bus.req_data[32*w_win +: 32];

    assign bus.req_ready  = w_ready;
    assign bus.sdo        = r_sdo;
    assign bus.busy       = r_busy;
    assign bus.grant_id   = r_grant_id;
    assign bus.frame_done = r_frame_done;

    // Frame FSM: accept, preamble 1010, payload MSB-first, then a low gap before returning to IDLE.
    always_ff @(posedge t_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_shift      <= '0;
            r_ptr        <= GID_W'(NUM_REQ - 1);
            r_grant_id   <= '0;
            r_sdo        <= 1'b0;
            r_busy       <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_shift    <= w_win_data;
                        r_grant_id <= w_win;
                        r_ptr      <= w_win;
                        r_busy     <= 1'b1;
                        r_sdo      <= 1'b1;
                        r_cnt      <= '0;
                        r_state    <= S_PRE;
                    end
                end
                S_PRE: begin
                    if (r_cnt == PRE_LAST) begin
                        r_sdo   <= r_shift[31];
                        r_shift <= {r_shift[30:0], 1'b0};
                        r_cnt   <= '0;
                        r_state <= S_DATA;
                    end else begin
                        // after bit k of the preamble (k = cnt) the next bit is 0,1,0
                        r_sdo <= r_cnt[0];
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                S_DATA: begin
                    if (r_cnt == DATA_LAST) begin
                        r_sdo   <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_GAP;
                    end else begin
                        r_sdo   <= r_shift[31];
                        r_shift <= {r_shift[30:0], 1'b0};
                        r_cnt   <= r_cnt + 6'd1;
                    end
                end
                S_GAP: begin
                    r_sdo <= 1'b0;
                    // registered pulse lands in the final gap cycle
                    if (r_cnt == GAP_DONE) begin
                        r_frame_done <= 1'b1;
                    end
                    if (r_cnt == GAP_LAST) begin
                        r_busy  <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 6'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef ST_LINK_TX_STATS_EN
    logic [15:0]        r_frame_cnt;
    logic [NUM_REQ-1:0] r_grant_hist;

    // Count completed frames (wrapping) and keep a sticky record of every requester ever granted.
    always_ff @(posedge t_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt  <= '0;
            r_grant_hist <= '0;
        end else begin
            if (r_frame_done) begin
                r_frame_cnt <= r_frame_cnt + 16'd1;
            end
            r_grant_hist <= r_grant_hist | w_ready;
        end
    end

    assign frame_cnt  = r_frame_cnt;
    assign grant_hist = r_grant_hist;
`endif

endmodule

// File: tb/tb_st_link_tx_sched.sv
// tb/tb_st_link_tx_sched.sv - self-checking bench for st_link_tx_sched against a frame-timeline model
`timescale 1ns/1ps

module tb_st_link_tx_sched;

    localparam int NR    = 4;
    localparam int G     = 8;
    localparam int FRAME = 36 + G;

    logic t_clk = 1'b0;
    logic rst_n = 1'b0;

    st_link_tx_sched_if #(.NUM_REQ(NR)) bus ();

`ifdef ST_LINK_TX_STATS_EN
    logic [15:0]   frame_cnt;
    logic [NR-1:0] grant_hist;
`endif

    st_link_tx_sched #(
        .NUM_REQ    (NR),
        .PAYLOAD_W  (32),
        .GAP_CYCLES (G)
    ) dut (
        .t_clk      (t_clk),
        .rst_n      (rst_n),
        .bus        (bus)
`ifdef ST_LINK_TX_STATS_EN
        ,
        .frame_cnt  (frame_cnt),
        .grant_hist (grant_hist)
`endif
    );

    always #5 t_clk = ~t_clk;

    int n_cmp = 0;
    int n_bad = 0;
    int g_cyc = 0;

    // model: m_n = cycle number N after the accept edge (0 = idle)
    int          m_n;
    logic [31:0] m_word;
    int          m_ptr;
    int          m_gid;
    logic [NR-1:0] m_hist;
    int          m_frames;

    // observations of the DUT for the hand-computed checks
    int   acc_cyc[$];
    int   acc_id[$];
    int   last_acc = -100000;
    logic [3:0]  cap_pre;
    logic [31:0] cap_pay;
    int   gap_cnt, gap_ones, fd_off, rdy_cnt;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, g_cyc);
        end
    endtask

    function automatic int rr_winner(input int ptr, input logic [NR-1:0] v);
        for (int k = 1; k <= NR; k++) begin
            if (v[(ptr + k) % NR]) return (ptr + k) % NR;
        end
        return -1;
    endfunction

    function automatic int onehot_idx(input logic [NR-1:0] r);
        for (int i = 0; i < NR; i++) begin
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_n      = 0;
        m_word   = '0;
        m_ptr    = NR - 1;
        m_gid    = 0;
        m_hist   = '0;
        m_frames = 0;
    endtask

    // One clock cycle: called at a negedge with inputs already driven.
    task automatic cyc();
        int            w;
        int            off;
        logic [NR-1:0] er;
        logic          es;
        #1;
        w  = (m_n == 0 && bus.enable) ? rr_winner(m_ptr, bus.req_valid) : -1;
        er = (w >= 0) ? (NR'(1) << w) : '0;
        es = 1'b0;
        if (m_n >= 1 && m_n <= 4)       es = m_n[0];
        else if (m_n >= 5 && m_n <= 36) es = m_word[36 - m_n];
        chk("req_ready",  32'(bus.req_ready),  32'(er));
        chk("sdo",        32'(bus.sdo),        32'(es));
        chk("busy",       32'(bus.busy),       32'(m_n != 0));
        chk("frame_done", 32'(bus.frame_done), 32'(m_n == FRAME));
        chk("grant_id",   32'(bus.grant_id),   32'(m_gid));

        if (bus.req_ready != 0) rdy_cnt++;
        if ((bus.req_ready & bus.req_valid) != 0) begin
            acc_cyc.push_back(g_cyc);
            acc_id.push_back(onehot_idx(bus.req_ready));
            last_acc = g_cyc;
            cap_pre  = '0;
            cap_pay  = '0;
            gap_cnt  = 0;
            gap_ones = 0;
            fd_off   = -1;
        end
        off = g_cyc - last_acc;
        if (off >= 1 && off <= 4)       cap_pre = {cap_pre[2:0], bus.sdo};
        else if (off >= 5 && off <= 36) cap_pay = {cap_pay[30:0], bus.sdo};
        else if (off >= 37 && off <= FRAME) begin
            gap_cnt++;
            if (bus.sdo) gap_ones++;
        end
        if (bus.frame_done) fd_off = off;

        @(posedge t_clk);
        if (w >= 0) begin
            m_n       = 1;
            m_word    = bus.req_data[32*w +: 32];
            m_ptr     = w;
            m_gid     = w;
            m_hist[w] = 1'b1;
        end else if (m_n == FRAME) begin
            m_n = 0;
            m_frames++;
        end else if (m_n > 0) begin
            m_n++;
        end
        g_cyc++;
        @(negedge t_clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int k;

        model_reset();
        bus.enable    = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        rst_n         = 1'b0;

        // reset values, with requests offered while held in reset
        repeat (3) @(negedge t_clk);
        bus.enable    = 1'b1;
        bus.req_valid = '1;
        #1;
        chk("rst_sdo",        32'(bus.sdo),        0);
        chk("rst_busy",       32'(bus.busy),       0);
        chk("rst_grant_id",   32'(bus.grant_id),   0);
        chk("rst_frame_done", 32'(bus.frame_done), 0);
        chk("rst_req_ready",  32'(bus.req_ready),  0);
        bus.req_valid = '0;
        @(negedge t_clk);
        rst_n = 1'b1;

        // single request from requester 2; data scrambled after accept
        rdy_cnt = 0;
        bus.req_data = {$urandom, $urandom, $urandom, $urandom};
        bus.req_data[64 +: 32] = 32'hA5C3_0F81;
        bus.req_valid = 4'b0100;
        cyc();
        bus.req_valid = '0;
        for (int i = 0; i < FRAME; i++) begin
            bus.req_data = {$urandom, $urandom, $urandom, $urandom};
            cyc();
        end
        chk("t1_grant",      32'(acc_id[$]),     2);
        chk("t1_ready_cyc",  32'(rdy_cnt),       1);
        chk("t1_preamble",   32'(cap_pre),       32'hA);
        chk("t1_payload",    cap_pay,            32'hA5C3_0F81);
        chk("t1_gap_len",    32'(gap_cnt),       8);
        chk("t1_gap_ones",   32'(gap_ones),      0);
        chk("t1_done_cycle", 32'(fd_off),        44);
        chk("t1_grant_id",   32'(bus.grant_id),  2);

        // reset pulsed in the middle of a payload from requester 1
        bus.req_data  = {$urandom, $urandom, $urandom, $urandom};
        bus.req_valid = 4'b0010;
        cyc();
        bus.req_valid = '0;
        repeat (24) cyc();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t2_rst_sdo",  32'(bus.sdo),  0);
        chk("t2_rst_busy", 32'(bus.busy), 0);
        model_reset();
        bus.req_valid = '1;
        @(negedge t_clk);
        rst_n = 1'b1;

        // all four requesters held valid: strict round-robin from requester 0
        n0 = acc_id.size();
        for (int i = 0; i < 182; i++) begin
            bus.req_data = {$urandom, $urandom, $urandom, $urandom};
            cyc();
        end
        chk("t3_count", 32'(acc_id.size() - n0), 5);
        if (acc_id.size() - n0 >= 5) begin
            for (int i = 0; i < 5; i++) begin
                chk("t3_order", 32'(acc_id[n0 + i]), 32'(i % 4));
            end
            for (int i = 0; i < 4; i++) begin
                chk("t3_spacing", 32'(acc_cyc[n0 + i + 1] - acc_cyc[n0 + i]), 45);
            end
        end

        // enable dropped at payload bit 10 of the next frame
        n0 = acc_id.size();
        k  = 0;
        while (acc_id.size() == n0 && k < 100) begin
            cyc();
            k++;
        end
        chk("t4_accept_seen", 32'(acc_id.size() - n0), 1);
        repeat (14) cyc();
        bus.enable = 1'b0;
        n0 = acc_id.size();
        for (int i = 0; i < 60; i++) begin
            bus.req_data = {$urandom, $urandom, $urandom, $urandom};
            cyc();
        end
        chk("t4_no_grant_disabled", 32'(acc_id.size() - n0), 0);
        bus.enable = 1'b1;
        cyc();
        chk("t4_resume", 32'(acc_id.size() - n0), 1);
        chk("t4_resume_cycle", 32'(acc_cyc[$]), 32'(g_cyc - 1));

        // randomized traffic against the model
        for (int i = 0; i < 900; i++) begin
            bus.enable    = ($urandom_range(0, 7) != 0);
            bus.req_valid = NR'($urandom);
            bus.req_data  = {$urandom, $urandom, $urandom, $urandom};
            cyc();
        end

`ifdef ST_LINK_TX_STATS_EN
        chk("stats_grant_hist", 32'(grant_hist), 32'(m_hist));
        chk("stats_frame_cnt",  32'(frame_cnt),  32'(m_frames));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
